board_scan_display: RTL and testbench
=====================================

Name: board_scan_display

Overview:
- Downstream stage of the game datapath. Consumes the 25-bit mine and cleared board vectors after each move.
- Walks the 5x5 board cell by cell. For each cleared cell it computes the adjacent-mine count (0..8).
- Streams one beat per cell (index, cell state, count) to the display sink over a valid/ready handshake.
- Reports completion back to the main FSM.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns. Cell count N = ROWS*COLS = 25. Index i = row*COLS + col maps to bit i of every board vector.
- CNT_W, 4, width of the neighbour-count output.

Ports:
- in_clka  input  1  sole clock; all state changes on its rising edge.
- in_restart  input  1  reset; synchronous, active-high.
- in_display  input  1  start request; sampled only in IDLE.
- in_mines  input  25  mine bitmap.
- in_cleared  input  25  cleared-cell bitmap.
- in_gameover  input  1  game lost; reveal all mines.
- in_ready  input  1  display sink can accept a beat.
- out_valid  output  1  beat valid.
- out_temp_index  output  5  cell index 0..24 of the current beat.
- out_cell_state  output  2  00 hidden, 01 cleared, 10 mine shown, 11 unused.
- out_temp_mine_cnt  output  CNT_W  adjacent mines; 0 unless the state is 01.
- out_revealed_cnt  output  5  cleared cells scanned so far in this pass.
- out_display  output  1  busy; high in every state except IDLE.
- out_display_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: in_restart=1 at an edge forces IDLE, index 0, and every output to 0, overriding everything else. A reset mid-scan aborts the scan with no done pulse.
- States: IDLE, CALC, EMIT, DONE.
- IDLE:
  - When in_display=1, snapshot in_mines, in_cleared and in_gameover into internal registers.
  - Set index=0, out_revealed_cnt=0, go to CALC.
  - in_display outside IDLE is ignored.
  - After the snapshot, changes on the board inputs have no effect on the scan.
- CALC: one cycle. Register the beat for the current index, set out_valid=1, go to EMIT.
  - State 10 if the snapshot mine bit is set and (gameover or cleared bit set); mine takes precedence over cleared.
  - Else state 01 if the cleared bit is set.
  - Else state 00.
  - Count = popcount of the snapshot mine bits of the 8-connected neighbours inside the board. No wrap across row or column edges. Corner cells have 3 neighbours, edge cells 5, interior cells 8. Count is forced to 0 for states 00 and 10.
  - out_revealed_cnt increments by 1 when the state is 01.
- EMIT:
  - Hold all beat outputs stable while in_ready=0.
  - On an edge with out_valid=1 and in_ready=1: drop out_valid. If index=N-1, go to DONE; else index+1 and go to CALC.
- DONE: out_display_done=1 for exactly one cycle, then IDLE.
  - out_display falls on entry to IDLE.
  - out_temp_index, out_cell_state, out_temp_mine_cnt and out_revealed_cnt hold their last values until the next start.
- Timing with in_ready tied high, taking e0 as the edge that samples start:
  - Beat k is valid after edge e(2k+1) and transfers at edge e(2k+2).
  - DONE occupies the cycle after e50; IDLE is reached at e51.
- Widths: all counts are unsigned and cannot overflow (max 8 in 4 bits, max 25 in 5 bits).

Optional Feature:
- Macro: DISPLAY_SKIP_HIDDEN_EN.
- When defined:
  - CALC does not raise out_valid for a state-00 cell. It advances the index in the same cycle, or goes to DONE if the index is N-1.
  - An all-hidden board produces zero beats: 25 CALC cycles, then DONE.
- When undefined: every cell emits exactly one beat (25 beats per pass).

Test Plan:
- Reset: hold in_restart 2 cycles → all outputs 0, out_display=0. in_display while in reset → no scan starts.
- Centre cell: mines={0,6,24}, cleared={12}, in_ready=1, start → 25 beats with indices 0..24 in order.
  - Index 12: state 01, count 1. All other beats: state 00, count 0.
  - out_display_done in the cycle after e50; out_revealed_cnt=1.
  - With DISPLAY_SKIP_HIDDEN_EN: a single beat (index 12), then done.
- Edge/no-wrap: mines={1,5,6}, cleared={0,4} → index 0 count 3; index 4 count 0 (bit 5 is not adjacent to cell 4).
- Backpressure: in_ready=0 for 3 cycles while beat 12 is valid → out_valid stays 1 and index/state/count stay stable. The done pulse is delayed by exactly 3 cycles versus the scenario-2 timing.
- Gameover: in_gameover=1, mines={0,6,24}, cleared={} → indices 0, 6, 24 state 10 count 0; others state 00; out_revealed_cnt=0.
- Mid-scan reset: in_restart=1 during beat 10 → all outputs 0 next cycle, no done pulse. A new in_display restarts from index 0 and uses a fresh snapshot.

Source files
------------

// File: rtl/board_scan_display.sv
// Walks the 5x5 board once per display request and streams one beat per cell
// (index, state, adjacent-mine count). Optional DISPLAY_SKIP_HIDDEN_EN drops beats for hidden cells.
module board_scan_display #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 5,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 in_clka,
  input  logic                 in_restart,
  input  logic                 in_display,
  input  logic [ROWS*COLS-1:0] in_mines,
  input  logic [ROWS*COLS-1:0] in_cleared,
  input  logic                 in_gameover,
  input  logic                 in_ready,
  output logic                 out_valid,
  output logic [4:0]           out_temp_index,
  output logic [1:0]           out_cell_state,
  output logic [CNT_W-1:0]     out_temp_mine_cnt,
  output logic [4:0]           out_revealed_cnt,
  output logic                 out_display,
  output logic                 out_display_done
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [1:0] {StIdle, StCalc, StEmit, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    mines_q;
  logic [N-1:0]    cleared_q;
  logic            gameover_q;
  logic [4:0]      idx_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;

  logic [1:0]      cur_state;
  logic [CNT_W-1:0] nbr_cnt;
  logic            last_cell;
  logic [4:0]      idx_nxt;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_nxt;

  // Mine takes precedence over cleared; mines only show once cleared or on game over.
  always_comb begin
    cur_state = 2'b00;
    if (mines_q[idx_q] && (gameover_q || cleared_q[idx_q])) begin
      cur_state = 2'b10;
    end else if (cleared_q[idx_q]) begin
      cur_state = 2'b01;
    end
  end

  // Row/column distance test against every cell; no wrap across board edges.
  always_comb begin
    int jr;
    int jc;
    int dr;
    int dc;
    nbr_cnt = '0;
    jr = 0;
    jc = 0;
    dr = 0;
    dc = 0;
    for (int j = 0; j < N; j++) begin
      jr = j / COLS;
      jc = j % COLS;
      dr = jr - int'(row_q);
      dc = jc - int'(col_q);
      if (mines_q[j] && (dr != 0 || dc != 0) && dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) begin
        nbr_cnt = nbr_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    last_cell = (idx_q == 5'(N - 1));
    idx_nxt   = idx_q + 5'd1;
    row_nxt   = row_q;
    col_nxt   = col_q + CW'(1);
    if (col_q == CW'(COLS - 1)) begin
      col_nxt = '0;
      row_nxt = row_q + RW'(1);
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_q           <= StIdle;
      mines_q           <= '0;
      cleared_q         <= '0;
      gameover_q        <= 1'b0;
      idx_q             <= '0;
      row_q             <= '0;
      col_q             <= '0;
      out_valid         <= 1'b0;
      out_temp_index    <= '0;
      out_cell_state    <= '0;
      out_temp_mine_cnt <= '0;
      out_revealed_cnt  <= '0;
      out_display       <= 1'b0;
      out_display_done  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          out_display_done <= 1'b0;
          if (in_display) begin
            mines_q          <= in_mines;
            cleared_q        <= in_cleared;
            gameover_q       <= in_gameover;
            idx_q            <= '0;
            row_q            <= '0;
            col_q            <= '0;
            out_revealed_cnt <= '0;
            out_display      <= 1'b1;
            state_q          <= StCalc;
          end
        end
        StCalc: begin
`ifdef DISPLAY_SKIP_HIDDEN_EN
          if (cur_state == 2'b00) begin
            if (last_cell) begin
              out_display_done <= 1'b1;
              state_q          <= StDone;
            end else begin
              idx_q <= idx_nxt;
              row_q <= row_nxt;
              col_q <= col_nxt;
            end
          end else begin
            out_temp_index    <= idx_q;
            out_cell_state    <= cur_state;
            out_temp_mine_cnt <= (cur_state == 2'b01) ? nbr_cnt : '0;
            if (cur_state == 2'b01) begin
              out_revealed_cnt <= out_revealed_cnt + 5'd1;
            end
            out_valid <= 1'b1;
            state_q   <= StEmit;
          end
`else
          out_temp_index    <= idx_q;
          out_cell_state    <= cur_state;
          out_temp_mine_cnt <= (cur_state == 2'b01) ? nbr_cnt : '0;
          if (cur_state == 2'b01) begin
            out_revealed_cnt <= out_revealed_cnt + 5'd1;
          end
          out_valid <= 1'b1;
          state_q   <= StEmit;
`endif
        end
        StEmit: begin
          if (out_valid && in_ready) begin
            out_valid <= 1'b0;
            if (last_cell) begin
              out_display_done <= 1'b1;
              state_q          <= StDone;
            end else begin
              idx_q   <= idx_nxt;
              row_q   <= row_nxt;
              col_q   <= col_nxt;
              state_q <= StCalc;
            end
          end
        end
        StDone: begin
          out_display_done <= 1'b0;
          out_display      <= 1'b0;
          state_q          <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scan_display.sv
// Scoreboard bench for board_scan_display: a reference model queues the expected beats per pass
// and a negedge monitor pops and compares each transferred beat.
module tb_board_scan_display;

  logic        clk = 1'b0;
  logic        in_restart;
  logic        in_display;
  logic [24:0] in_mines;
  logic [24:0] in_cleared;
  logic        in_gameover;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_temp_index;
  logic [1:0]  out_cell_state;
  logic [3:0]  out_temp_mine_cnt;
  logic [4:0]  out_revealed_cnt;
  logic        out_display;
  logic        out_display_done;

  always #5 clk = ~clk;

  board_scan_display dut (
    .in_clka          (clk),
    .in_restart       (in_restart),
    .in_display       (in_display),
    .in_mines         (in_mines),
    .in_cleared       (in_cleared),
    .in_gameover      (in_gameover),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_temp_index   (out_temp_index),
    .out_cell_state   (out_cell_state),
    .out_temp_mine_cnt(out_temp_mine_cnt),
    .out_revealed_cnt (out_revealed_cnt),
    .out_display      (out_display),
    .out_display_done (out_display_done)
  );

  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] st;
    logic [3:0] cnt;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_rev;
  int    exp_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: expected beats, revealed count and start-to-done cycle count.
  task automatic build_exp(input logic [24:0] m, input logic [24:0] c, input logic go,
                           input int stall_cell);
    beat_t b;
    int    r, cl, n, rr, cc;
    logic [1:0] st;
    logic  emit;
    exp_rev    = 0;
    exp_cycles = 0;
    for (int i = 0; i < 25; i++) begin
      r  = i / 5;
      cl = i % 5;
      n  = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = cl + dc;
          if ((dr != 0 || dc != 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5) begin
            if (m[rr*5+cc]) n++;
          end
        end
      end
      if (m[i] && (go || c[i])) st = 2'b10;
      else if (c[i])            st = 2'b01;
      else                      st = 2'b00;
      if (st == 2'b01) exp_rev++;
      emit = 1'b1;
`ifdef DISPLAY_SKIP_HIDDEN_EN
      emit = (st != 2'b00);
`endif
      if (emit) begin
        b.idx = 5'(i);
        b.st  = st;
        b.cnt = (st == 2'b01) ? 4'(n) : 4'd0;
        exp_q.push_back(b);
        exp_cycles += (i == stall_cell) ? 5 : 2;
      end else begin
        exp_cycles += 1;
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!in_restart && out_valid && in_ready) begin
      check_eq("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("beat_index", out_temp_index, e.idx);
        check_eq("beat_state", out_cell_state, e.st);
        check_eq("beat_count", out_temp_mine_cnt, e.cnt);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_index"}, out_temp_index, 0);
    check_eq({tag, "_state"}, out_cell_state, 0);
    check_eq({tag, "_count"}, out_temp_mine_cnt, 0);
    check_eq({tag, "_revealed"}, out_revealed_cnt, 0);
    check_eq({tag, "_busy"}, out_display, 0);
    check_eq({tag, "_done"}, out_display_done, 0);
  endtask

  // Starts a pass, scrambles the board inputs afterwards and waits (bounded) for the done pulse.
  task automatic run_scan(input string name, input logic [24:0] m, input logic [24:0] c,
                          input logic go, input int stall_cell);
    int          n;
    logic        stalled;
    logic [10:0] held;
    build_exp(m, c, go, stall_cell);
    in_mines    = m;
    in_cleared  = c;
    in_gameover = go;
    in_display  = 1'b1;
    @(posedge clk);
    #1;
    in_display  = 1'b0;
    in_mines    = 25'($urandom);
    in_cleared  = 25'($urandom);
    in_gameover = ~go;
    n       = 0;
    stalled = 1'b0;
    while (!out_display_done && n < 400) begin
      if (out_valid && !stalled && int'(out_temp_index) == stall_cell) begin
        stalled  = 1'b1;
        in_ready = 1'b0;
        held     = {out_temp_index, out_cell_state, out_temp_mine_cnt};
        repeat (3) begin
          @(posedge clk);
          #1;
          n++;
          check_eq({name, "_stall_valid"}, out_valid, 1);
          check_eq({name, "_stall_hold"}, {out_temp_index, out_cell_state, out_temp_mine_cnt},
                   held);
        end
        in_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({name, "_done_cycle"}, n, exp_cycles);
    check_eq({name, "_busy_in_done"}, out_display, 1);
    check_eq({name, "_revealed"}, out_revealed_cnt, exp_rev);
    check_eq({name, "_beats_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq({name, "_done_pulse_end"}, out_display_done, 0);
    check_eq({name, "_idle_busy"}, out_display, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    in_restart  = 1'b1;
    in_display  = 1'b1;
    in_mines    = 25'h1000041;
    in_cleared  = 25'h1;
    in_gameover = 1'b0;
    in_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    in_restart = 1'b0;
    in_display = 1'b0;
    @(posedge clk);
    #1;
    check_eq("no_start_after_reset", out_display, 0);

    run_scan("centre", 25'h1000041, 25'h0001000, 1'b0, -1);
    run_scan("edge", 25'h0000062, 25'h0000011, 1'b0, -1);
    run_scan("backpressure", 25'h1000041, 25'h0001000, 1'b0, 12);
    run_scan("gameover", 25'h1000041, 25'h0000000, 1'b1, -1);

    // Mid-scan reset while beat 10 is on the bus.
    build_exp(25'h1ffffff, 25'h1ffffff, 1'b0, -1);
    in_mines   = 25'h1ffffff;
    in_cleared = 25'h1ffffff;
    in_display = 1'b1;
    @(posedge clk);
    #1;
    in_display = 1'b0;
    n = 0;
    while (!(out_valid && out_temp_index == 5'd10) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("midreset_reached_beat10", out_temp_index, 10);
    in_restart = 1'b1;
    @(posedge clk);
    #1;
    in_restart = 1'b0;
    exp_q.delete();
    check_all_zero("midreset");
    repeat (4) begin
      @(posedge clk);
      #1;
      check_eq("midreset_no_done", out_display_done, 0);
    end
    run_scan("fresh", 25'h0001000, 25'h00729c0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
